// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          INST_W           = 32;
  localparam int          ADDR_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered instruction queue (no bypass); flush wins over push in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               push_entry,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == CNT_W'(0));
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (do_push && (wr_ptr_q == PTR_W'(i))) ? push_entry : mem_q[i];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = do_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = do_pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// capture into fetch_fifo, and redirect handling with stale-response discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q;
  logic [ADDR_W-1:0] resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  outstanding_d;
  logic [CNT_W-1:0]  discard_q;
  logic [CNT_W-1:0]  discard_d;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W:0]    credit_used;
  logic              req_fire;
  logic              resp_stale;
  logic              resp_push;
  logic              ir_pop;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (resp_push),
    .pop        (ir_pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (occupancy)
  );

  assign imem_req_addr = fetch_pc_q;
  assign ir_valid      = !fifo_empty;
  assign ir            = ir_valid ? head_entry.inst : '0;
  assign ir_pc         = ir_valid ? head_entry.pc : '0;
  assign ir_pop        = ir_valid && ir_ready;

  // Stale in-flight requests do not hold queue credit: their slots are never filled.
  always_comb begin
    credit_used    = {1'b0, occupancy} + {1'b0, outstanding_q} - {1'b0, discard_q};
    imem_req_valid = !rst && (credit_used < (CNT_W+1)'(DEPTH))
                     && (outstanding_q < CNT_W'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    resp_stale     = imem_resp_valid && (redirect_valid || (discard_q != CNT_W'(0)));
    resp_push      = imem_resp_valid && !resp_stale && !fifo_full;
    push_entry     = '0;
    push_entry.inst = imem_resp_data;
    push_entry.pc   = resp_pc_q;
    outstanding_d  = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

    if (redirect_valid) begin
      discard_d = outstanding_d;
    end else if (imem_resp_valid && (discard_q != CNT_W'(0))) begin
      discard_d = discard_q - CNT_W'(1);
    end else begin
      discard_d = discard_q;
    end

    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (redirect_valid) begin
      resp_pc_d = align_pc(redirect_pc);
    end else if (resp_push) begin
      resp_pc_d = resp_pc_q + PC_STEP;
    end else begin
      resp_pc_d = resp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= align_pc(RESET_PC);
      resp_pc_q     <= align_pc(RESET_PC);
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an in-order latency-L memory model.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;

  int checks = 0;
  int errors = 0;
  int cyc;
  int full_viol;
  int mem_lat = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_inst[$];
  int          del_cyc[$];

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .ir              (ir),
    .ir_pc           (ir_pc)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= ~pend_addr[0];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
        if (dut.u_fifo.full && dut.discard_q == 3'd0 && !redirect_valid) full_viol <= full_viol + 1;
      end else begin
        imem_resp_valid <= 1'b0;
        imem_resp_data  <= 32'h0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + mem_lat);
        req_log.push_back(imem_req_addr);
      end
      if (ir_valid && ir_ready) begin
        del_pc.push_back(ir_pc);
        del_inst.push_back(ir);
        del_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [31:0] rq(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dpc(input int i);
    return (i < del_pc.size()) ? del_pc[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dinst(input int i);
    return (i < del_inst.size()) ? del_inst[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic int dcyc(input int i);
    return (i < del_cyc.size()) ? del_cyc[i] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    del_pc.delete();
    del_inst.delete();
    del_cyc.delete();
  endtask

  // Leaves the bench at the start of the first cycle after reset release.
  task automatic do_start(input int lat, input logic rdy, output int c0);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step(2);
    clear_logs();
    mem_lat = lat;
    ir_ready = rdy;
    rst = 1'b0;
    c0 = cyc;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b expected 0", imem_req_valid); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid: got %0b expected 0", ir_valid); end
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected 0", ir); end
    checks++; if (ir_pc !== 32'h0) begin errors++; $display("FAIL reset_ir_pc: got %h expected 0", ir_pc); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_req_addr); end
    checks++; if (dut.outstanding_q !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", dut.outstanding_q); end
  endtask

  task automatic test_stream();
    int c0;
    logic [31:0] exp;
    do_start(1, 1'b1, c0);
    step(12);
    for (int i = 0; i < 8; i++) begin
      exp = 32'(4 * i);
      checks++; if (rq(i) !== exp) begin errors++; $display("FAIL stream_req[%0d]: got %h expected %h", i, rq(i), exp); end
      checks++; if (dpc(i) !== exp) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, dpc(i), exp); end
      checks++; if (dinst(i) !== ~exp) begin errors++; $display("FAIL stream_ir[%0d]: got %h expected %h", i, dinst(i), ~exp); end
    end
    checks++; if (dcyc(0) - c0 !== 2) begin errors++; $display("FAIL stream_latency: got %0d expected 2", dcyc(0) - c0); end
    checks++; if (dcyc(7) - dcyc(0) !== 7) begin errors++; $display("FAIL stream_rate: got %0d expected 7", dcyc(7) - dcyc(0)); end
  endtask

  task automatic test_backpressure();
    int c0;
    logic [31:0] exp;
    do_start(1, 1'b0, c0);
    step(8);
    checks++; if (req_log.size() !== 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
    checks++; if (rq(3) !== 32'hC) begin errors++; $display("FAIL bp_req3: got %h expected 0000000c", rq(3)); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stall: got %0b expected 0", imem_req_valid); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL bp_ir_valid: got %0b expected 1", ir_valid); end
    checks++; if (ir_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 0", ir_pc); end
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL bp_occupancy: got %0d expected 4", dut.u_fifo.count); end
    ir_ready = 1'b1;
    step(10);
    for (int i = 0; i < 5; i++) begin
      exp = 32'(4 * i);
      checks++; if (dpc(i) !== exp) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, dpc(i), exp); end
    end
    checks++; if (rq(4) !== 32'h10) begin errors++; $display("FAIL bp_resume: got %h expected 00000010", rq(4)); end
  endtask

  task automatic test_redirect_drop();
    int c0;
    int old_path;
    do_start(3, 1'b1, c0);
    step(2);
    checks++; if (dut.outstanding_q !== 3'd2) begin errors++; $display("FAIL rd_pre_outstanding: got %0d expected 2", dut.outstanding_q); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    checks++; if (dut.discard_q !== 3'd3) begin errors++; $display("FAIL rd_discard: got %0d expected 3", dut.discard_q); end
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL rd_addr: got %h expected 00000100", imem_req_addr); end
    step(12);
    checks++; if (dpc(0) !== 32'h100) begin errors++; $display("FAIL rd_first_pc: got %h expected 00000100", dpc(0)); end
    checks++; if (dpc(1) !== 32'h104) begin errors++; $display("FAIL rd_second_pc: got %h expected 00000104", dpc(1)); end
    checks++; if (dcyc(0) - c0 !== 7) begin errors++; $display("FAIL rd_first_cycle: got %0d expected 7", dcyc(0) - c0); end
    old_path = 0;
    foreach (del_pc[i]) if (del_pc[i] < 32'h100) old_path++;
    checks++; if (old_path !== 0) begin errors++; $display("FAIL rd_old_path: got %0d expected 0", old_path); end
  endtask

  task automatic test_misaligned();
    int c0;
    do_start(1, 1'b1, c0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step(1);
    redirect_valid = 1'b0;
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL mis_addr: got %h expected 00000100", imem_req_addr); end
    step(6);
    checks++; if (dpc(0) !== 32'h100) begin errors++; $display("FAIL mis_pc: got %h expected 00000100", dpc(0)); end
    checks++; if (dinst(0) !== ~32'h100) begin errors++; $display("FAIL mis_ir: got %h expected %h", dinst(0), ~32'h100); end
    checks++; if (rq(1) !== 32'h100) begin errors++; $display("FAIL mis_req: got %h expected 00000100", rq(1)); end
    checks++; if (dcyc(0) - c0 !== 3) begin errors++; $display("FAIL mis_cycle: got %0d expected 3", dcyc(0) - c0); end
  endtask

  task automatic test_redirect_collision();
    int c0;
    do_start(1, 1'b1, c0);
    step(3);
    checks++; if (ir_pc !== 32'h4) begin errors++; $display("FAIL col_pre_head: got %h expected 00000004", ir_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL col_empty: got %0b expected 0", ir_valid); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL col_count: got %0d expected 0", dut.u_fifo.count); end
    checks++; if (dut.outstanding_q !== 3'd1) begin errors++; $display("FAIL col_outstanding: got %0d expected 1", dut.outstanding_q); end
    checks++; if (dut.discard_q !== 3'd1) begin errors++; $display("FAIL col_discard: got %0d expected 1", dut.discard_q); end
    checks++; if (dpc(1) !== 32'h4) begin errors++; $display("FAIL col_popped: got %h expected 00000004", dpc(1)); end
    checks++; if (rq(3) !== 32'hC) begin errors++; $display("FAIL col_stale_req: got %h expected 0000000c", rq(3)); end
    step(6);
    checks++; if (dpc(2) !== 32'h200) begin errors++; $display("FAIL col_next_pc: got %h expected 00000200", dpc(2)); end
    checks++; if (dcyc(2) - c0 !== 6) begin errors++; $display("FAIL col_next_cycle: got %0d expected 6", dcyc(2) - c0); end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_start(3, 1'b1, c0);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step(1);
    redirect_pc = 32'h500;
    step(1);
    redirect_valid = 1'b0;
    checks++; if (dut.discard_q !== 3'd3) begin errors++; $display("FAIL b2b_discard: got %0d expected 3", dut.discard_q); end
    checks++; if (imem_req_addr !== 32'h500) begin errors++; $display("FAIL b2b_addr: got %h expected 00000500", imem_req_addr); end
    step(10);
    checks++; if (rq(2) !== 32'h300) begin errors++; $display("FAIL b2b_req2: got %h expected 00000300", rq(2)); end
    checks++; if (dpc(0) !== 32'h500) begin errors++; $display("FAIL b2b_pc0: got %h expected 00000500", dpc(0)); end
    checks++; if (dpc(1) !== 32'h504) begin errors++; $display("FAIL b2b_pc1: got %h expected 00000504", dpc(1)); end
    checks++; if (dcyc(0) - c0 !== 7) begin errors++; $display("FAIL b2b_cycle: got %0d expected 7", dcyc(0) - c0); end
  endtask

  task automatic test_wrap();
    int c0;
    logic [31:0] exp;
    do_start(1, 1'b1, c0);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step(1);
    redirect_valid = 1'b0;
    step(8);
    for (int i = 0; i < 4; i++) begin
      exp = 32'hFFFF_FFF8 + 32'(4 * i);
      checks++; if (rq(i + 1) !== exp) begin errors++; $display("FAIL wrap_req[%0d]: got %h expected %h", i, rq(i + 1), exp); end
      checks++; if (dpc(i) !== exp) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, dpc(i), exp); end
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    do_start(3, 1'b0, c0);
    step(5);
    checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL rm_pre_count: got %0d expected 2", dut.u_fifo.count); end
    checks++; if (dut.outstanding_q !== 3'd2) begin errors++; $display("FAIL rm_pre_outstanding: got %0d expected 2", dut.outstanding_q); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_req_in_rst: got %0b expected 0", imem_req_valid); end
    step(1);
    rst = 1'b0;
    mem_lat = 1;
    clear_logs();
    #1;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rm_ir_valid: got %0b expected 0", ir_valid); end
    checks++; if (ir_pc !== 32'h0) begin errors++; $display("FAIL rm_ir_pc: got %h expected 0", ir_pc); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", dut.u_fifo.count); end
    checks++; if (dut.outstanding_q !== 3'd0) begin errors++; $display("FAIL rm_outstanding: got %0d expected 0", dut.outstanding_q); end
    checks++; if (dut.discard_q !== 3'd0) begin errors++; $display("FAIL rm_discard: got %0d expected 0", dut.discard_q); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h expected 0", imem_req_addr); end
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rm_req_valid: got %0b expected 1", imem_req_valid); end
    ir_ready = 1'b1;
    c0 = cyc;
    step(6);
    checks++; if (rq(0) !== 32'h0) begin errors++; $display("FAIL rm_restart_req: got %h expected 0", rq(0)); end
    checks++; if (dpc(0) !== 32'h0) begin errors++; $display("FAIL rm_restart_pc: got %h expected 0", dpc(0)); end
    checks++; if (dpc(1) !== 32'h4) begin errors++; $display("FAIL rm_restart_pc1: got %h expected 00000004", dpc(1)); end
    checks++; if (dcyc(0) - c0 !== 2) begin errors++; $display("FAIL rm_restart_cycle: got %0d expected 2", dcyc(0) - c0); end
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    ir_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_misaligned();
    test_redirect_collision();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    step(1);
    checks++; if (full_viol !== 0) begin errors++; $display("FAIL resp_into_full_queue: got %0d expected 0", full_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
